// File: rtl/tt_um_clk_period_meter_if.sv
// Pin bundle for the period meter: design enable, the dedicated input byte,
// the output byte and the bidirectional pin group.
interface tt_um_clk_period_meter_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/tt_um_clk_period_meter.sv
// Clock-period meter: counts clk cycles between consecutive rising edges of an
// asynchronous input, flags timeouts when no edge arrives within the counter
// range, and compares each measurement against a selectable expected ratio.
module tt_um_clk_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    tt_um_clk_period_meter_if.slave   pins
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   sigSynced;
    logic                   rise;
    logic                   clearReq;
    logic                   selHi;
    logic [1:0]             rsel;
    logic [CNT_W-1:0]       ratio;

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [CNT_W-1:0]       period_q;
    logic [CNT_W-1:0]       period_d;
    logic                   valid_q;
    logic                   valid_d;
    logic                   timeout_q;
    logic                   timeout_d;
    logic                   match_q;
    logic                   match_d;
    logic                   edge_q;
    logic                   edge_d;
    logic [15:0]            period16;
    logic                   unusedBits;

    assign sigSynced = sync_q[SYNC_STAGES-1];
    assign rise      = sigSynced & ~hist_q;
    assign clearReq  = pins.ui_in[2] | ~pins.ena;
    assign selHi     = pins.ui_in[1];
    assign rsel      = pins.ui_in[4:3];
    assign ratio     = CNT_W'(5'd2 << rsel);

    // Bring the measured signal into the clk domain and keep one history bit for rise detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pins.ui_in[0]};
            hist_q <= sigSynced;
        end
    end

    // State and measurement registers; clear is folded into the next-state logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            match_q   <= 1'b0;
            edge_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            match_q   <= match_d;
            edge_q    <= edge_d;
        end
    end

    // Next FSM state: a rise arms or restarts measurement, a full counter without a rise times out.
    always_comb begin
        state_d = state_q;
        if (clearReq) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (rise) state_d = MEASURE;
                MEASURE: if (!rise && cnt_q == CNT_MAX) state_d = TIMEOUT;
                TIMEOUT: if (rise) state_d = MEASURE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next counter, period and status flags; a rise on the last count still yields a valid period.
    always_comb begin
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        match_d   = match_q;
        edge_d    = rise;
        if (clearReq) begin
            cnt_d     = '0;
            period_d  = '0;
            valid_d   = 1'b0;
            timeout_d = 1'b0;
            match_d   = 1'b0;
            edge_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = rise ? CNT_ONE : '0;
                end
                MEASURE: begin
                    if (rise) begin
                        period_d  = cnt_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        match_d   = (cnt_q == ratio);
                        cnt_d     = CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        period_d  = CNT_MAX;
                        valid_d   = 1'b0;
                        timeout_d = 1'b1;
                        match_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                TIMEOUT: begin
                    if (rise) cnt_d = CNT_ONE;
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
    end

    assign period16     = 16'(period_q);
    assign pins.uo_out  = selHi ? period16[15:8] : period16[7:0];
    assign pins.uio_out = {4'b0000, edge_q, match_q, timeout_q, valid_q};
    assign pins.uio_oe  = 8'h0F;
    assign unusedBits   = &{1'b0, pins.ui_in[7:5], pins.uio_in};

endmodule

// File: tb/tb_tt_um_clk_period_meter.sv
// Scoreboard bench for the clock-period meter: stimulus pushes the expected
// outputs for every rise, a monitor pops and compares on each edge pulse.
module tb_tt_um_clk_period_meter;

    localparam int          CW   = 12;
    localparam logic [15:0] PMAX = 16'((1 << CW) - 1);

    typedef struct packed {
        logic [15:0] period;
        logic        valid;
        logic        timeout;
        logic        match;
    } expect_t;

    logic    clk = 1'b0;
    logic    rst_n;
    expect_t expQ[$];
    expect_t monExp;
    int      nChecks = 0;
    int      nFail   = 0;

    tt_um_clk_period_meter_if pins();

    tt_um_clk_period_meter #(
        .CNT_W(CW),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pins(pins)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic expectEdge(input logic [15:0] p, input logic v, input logic t, input logic m);
        expQ.push_back('{period: p, valid: v, timeout: t, match: m});
    endtask

    // One rise of sig followed by a low phase; called at a negedge, returns at a negedge.
    task automatic applyStimulus(input int highCycles, input int lowCycles);
        pins.ui_in[0] = 1'b1;
        repeat (highCycles) @(negedge clk);
        pins.ui_in[0] = 1'b0;
        repeat (lowCycles) @(negedge clk);
    endtask

    task automatic waitDrain(input string name);
        int waited = 0;
        while (expQ.size() != 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({name, " drained"}, 16'(expQ.size()), 16'd0);
    endtask

    task automatic checkZero(input string name);
        checkOutput({name, " uo_out"}, 16'(pins.uo_out), 16'h0000);
        checkOutput({name, " uio_out"}, 16'(pins.uio_out), 16'h0000);
    endtask

    task automatic doClear();
        pins.ui_in[2] = 1'b1;
        @(negedge clk);
        pins.ui_in[2] = 1'b0;
        checkZero("clear");
    endtask

    // Monitor: every edge pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && pins.uio_out[3]) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFail++;
                $display("[TB] FAIL unexpected edge: got uio_out %h, expected no edge", pins.uio_out);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("edge byte", 16'(pins.uo_out),
                            16'(pins.ui_in[1] ? monExp.period[15:8] : monExp.period[7:0]));
                checkOutput("edge flags", 16'(pins.uio_out[2:0]),
                            16'({monExp.match, monExp.timeout, monExp.valid}));
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        pins.ena    = 1'b1;
        pins.ui_in  = 8'h00;
        pins.uio_in = 8'h00;
        #2;
        checkZero("reset");
        checkOutput("reset uio_oe", 16'(pins.uio_oe), 16'h000F);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: edge appears on the third clk edge after sig rises.
        expectEdge(16'd0, 1'b0, 1'b0, 1'b0);
        pins.ui_in[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("latency early", 16'(pins.uio_out[3]), 16'd0);
        @(negedge clk);
        checkOutput("latency edge", 16'(pins.uio_out[3]), 16'd1);
        pins.ui_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        doClear();

        // clk/8 with ratio 8 expected.
        pins.ui_in[4:3] = 2'd2;
        expectEdge(16'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) expectEdge(16'd8, 1'b1, 1'b0, 1'b1);
        repeat (4) applyStimulus(4, 4);
        waitDrain("clk8");
        checkOutput("clk8 uo_out", 16'(pins.uo_out), 16'h0008);
        checkOutput("clk8 flags", 16'(pins.uio_out[2:0]), 16'h0005);

        // Selects do not disturb the stored measurement.
        pins.ui_in[4:3] = 2'd0;
        pins.ui_in[1]   = 1'b1;
        @(negedge clk);
        checkOutput("sel_hi clk8", 16'(pins.uo_out), 16'h0000);
        pins.ui_in[1] = 1'b0;
        @(negedge clk);
        checkOutput("rsel change uo_out", 16'(pins.uo_out), 16'h0008);
        checkOutput("rsel change flags", 16'(pins.uio_out[2:0]), 16'h0005);
        doClear();

        // clk/2 reads exactly 2.
        expectEdge(16'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) expectEdge(16'd2, 1'b1, 1'b0, 1'b1);
        repeat (3) applyStimulus(1, 1);
        waitDrain("clk2");
        doClear();

        // clk/16 with ratio 2 expected.
        expectEdge(16'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) expectEdge(16'd16, 1'b1, 1'b0, 1'b0);
        repeat (3) applyStimulus(8, 8);
        waitDrain("clk16");
        pins.ui_in[1] = 1'b1;
        @(negedge clk);
        checkOutput("clk16 hi", 16'(pins.uo_out), 16'h0000);
        pins.ui_in[1] = 1'b0;
        @(negedge clk);
        checkOutput("clk16 lo", 16'(pins.uo_out), 16'h0010);

        // ena low acts as clear.
        pins.ena = 1'b0;
        @(negedge clk);
        pins.ena = 1'b1;
        checkZero("ena clear");

        // Timeout after one rise, then recovery with a 300-cycle period.
        expectEdge(16'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, (1 << CW) + 20);
        checkOutput("timeout flags", 16'(pins.uio_out[2:0]), 16'h0002);
        checkOutput("timeout lo", 16'(pins.uo_out), 16'(PMAX[7:0]));
        pins.ui_in[1] = 1'b1;
        @(negedge clk);
        checkOutput("timeout hi", 16'(pins.uo_out), 16'(PMAX[15:8]));
        pins.ui_in[1] = 1'b0;
        expectEdge(PMAX, 1'b0, 1'b1, 1'b0);
        expectEdge(16'd300, 1'b1, 1'b0, 1'b0);
        applyStimulus(150, 150);
        applyStimulus(150, 150);
        waitDrain("recover");
        checkOutput("recover lo", 16'(pins.uo_out), 16'h002C);
        pins.ui_in[1] = 1'b1;
        @(negedge clk);
        checkOutput("recover hi", 16'(pins.uo_out), 16'h0001);
        pins.ui_in[1] = 1'b0;
        doClear();

        // Rise on the very last count is a valid maximum measurement.
        expectEdge(16'd0, 1'b0, 1'b0, 1'b0);
        expectEdge(PMAX, 1'b1, 1'b0, 1'b0);
        applyStimulus(1, int'(PMAX) - 1);
        applyStimulus(1, 10);
        waitDrain("max rise");
        checkOutput("max rise flags", 16'(pins.uio_out[2:0]), 16'h0001);
        doClear();

        // Clear in the same cycle as a rise wins; the next rise only arms.
        pins.ui_in[4:3] = 2'd2;
        expectEdge(16'd0, 1'b0, 1'b0, 1'b0);
        expectEdge(16'd8, 1'b1, 1'b0, 1'b1);
        repeat (2) applyStimulus(4, 4);
        waitDrain("pre clear");
        pins.ui_in[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pins.ui_in[2] = 1'b1;
        @(negedge clk);
        pins.ui_in[2] = 1'b0;
        checkZero("clear with rise");
        @(negedge clk);
        pins.ui_in[0] = 1'b0;
        repeat (4) @(negedge clk);
        expectEdge(16'd0, 1'b0, 1'b0, 1'b0);
        expectEdge(16'd8, 1'b1, 1'b0, 1'b1);
        repeat (2) applyStimulus(4, 4);
        waitDrain("after clear");

        // Asynchronous reset mid-measure, then clk/4 from scratch.
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkZero("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        pins.ui_in[4:3] = 2'd1;
        @(negedge clk);
        expectEdge(16'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) expectEdge(16'd4, 1'b1, 1'b0, 1'b1);
        repeat (3) applyStimulus(2, 2);
        waitDrain("clk4");
        checkOutput("clk4 uo_out", 16'(pins.uo_out), 16'h0004);

        repeat (5) @(negedge clk);
        checkOutput("queue empty", 16'(expQ.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/tt_um_clk_period_meter.md
TT_UM_CLK_PERIOD_METER -- requirements
Module: tt_um_clk_period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the period counter and period register (legal 9..16; upper bits read as 0 when <16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops on the measured signal (legal 2..3).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port ena  input  1  design enable; 0 behaves as clear (REQ-013).
REQ-006 SHALL have port ui_in  input  8  [0] measured signal sig (async), [1] byte select sel_hi, [2] synchronous clear, [4:3] expected-ratio select rsel, [7:5] unused.
REQ-007 SHALL have port uo_out  output  8  period byte: sel_hi=1 gives period[15:8], otherwise period[7:0]; combinational mux of registered period.
REQ-008 SHALL have port uio_in  input  8  unused, ignored.
REQ-009 SHALL have port uio_out  output  8  [0] valid, [1] timeout, [2] match, [3] edge pulse, [7:4] constant 0; bits [3:0] registered.
REQ-010 SHALL have port uio_oe  output  8  constant 8'h0F.

Function
REQ-011 sig SHALL pass through SYNC_STAGES flops plus one history flop; rise = synced high AND history low.
REQ-012 FSM SHALL have states IDLE, MEASURE, TIMEOUT; cnt is CNT_W-bit.
REQ-013 clear (ui_in[2]=1 or ena=0) SHALL, at the next clk edge, force IDLE, cnt=0, period=0, valid=0, timeout=0, match=0, edge=0; clear overrides all other events.
REQ-014 IDLE: cnt held 0; on rise -> MEASURE, cnt<=1, period unchanged, valid unchanged.
REQ-015 MEASURE, no rise, cnt < max: cnt<=cnt+1.
REQ-016 MEASURE, rise: period<=cnt, valid<=1, timeout<=0, cnt<=1; period equals clk cycles between consecutive detected rises.
REQ-017 MEASURE, no rise, cnt = 2^CNT_W-1: -> TIMEOUT, period<=all ones, valid<=0, timeout<=1.
REQ-018 Rise in the same cycle as cnt = max SHALL win: latch period=max as a valid measurement, no timeout.
REQ-019 TIMEOUT: cnt held; on rise -> MEASURE, cnt<=1, timeout stays 1 until next REQ-016 latch; no period latched from the timed-out interval.
REQ-020 edge SHALL be high exactly one cycle per detected rise (any state, not during clear).
REQ-021 match SHALL register (next_period == 2<<rsel), i.e. rsel 0/1/2/3 expects 2/4/8/16, updated whenever period is written; match=0 whenever valid=0.
REQ-022 Latency: pin rise stable before a clk edge SHALL appear on edge/period/valid SYNC_STAGES+1 clk edges later (3 at default).
REQ-023 Synchronous sources with high and low phases of at least 1 clk cycle SHALL measure exactly (clk/2 reads 2).
REQ-024 Changing rsel or sel_hi SHALL NOT alter FSM, cnt or period.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, all synchronizer/history flops 0, cnt=0, period=0, valid/timeout/match/edge=0, independent of clk.
REQ-026 Reset mid-MEASURE SHALL discard the partial count; first rise after release only arms (REQ-014).
REQ-027 Deassertion SHALL take effect at the first clk edge after rst_n rises; a sig already high then is detected as a rise.

Verification
REQ-028 sig = clk/8 synchronous square wave, rsel=2 -> after second rise, uo_out=8'h08, valid=1, match=1, edge pulses every 8 cycles.
REQ-029 sig = clk/16, rsel=0 -> period 16, valid=1, match=0; sel_hi=1 -> uo_out=8'h00.
REQ-030 sig held low 65535+ cycles after one rise -> timeout=1, valid=0, uo_out=8'hFF both bytes; next two rises 300 cycles apart -> period 300 (8'h2C/8'h01), timeout=0.
REQ-031 Rise arriving exactly when cnt=65535 -> period=16'hFFFF, valid=1, timeout=0.
REQ-032 ui_in[2] pulsed in the same cycle as a rise -> all outputs 0, state IDLE; next rise only arms.
REQ-033 rst_n asserted mid-measure without clk edge -> outputs 0 immediately; after release, sig=clk/4 -> first valid period 4 after two rises.
